// File: rtl/ahbl_excl_sram.sv
// ahbl_excl_sram
// AHB-Lite slave fronting a single-ported, word-organised SRAM with an
// exclusive-access monitor (LR/SC support). Reads and writes complete with
// zero wait states. Illegal accesses get a two-cycle ERROR response.
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   ahbls_hready_i            : bus-wide ready; an address phase is taken when
//                               it is high and htrans[1] is set
//   ahbls_hready_resp_o       : this slave's ready
//   ahbls_hresp_o             : 1 = ERROR
//   ahbls_haddr_i/hwrite_i/htrans_i/hsize_i : address-phase controls
//   ahbls_hburst_i/hprot_i/hmastlock_i      : accepted but ignored
//   ahbls_hwdata_i            : write data (data phase)
//   ahbls_hrdata_o            : read data (registered, data phase)
//   ahbls_hexcl_i             : exclusive transfer
//   ahbls_hmaster_i           : master ID, selects the reservation entry
//   ahbls_hexokay_o           : exclusive success (registered, data phase)
module ahbl_excl_sram #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int DEPTH     = 1024,
    parameter int N_MASTERS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ahbls_hready_i,
    output logic              ahbls_hready_resp_o,
    output logic              ahbls_hresp_o,
    input  logic [W_ADDR-1:0] ahbls_haddr_i,
    input  logic              ahbls_hwrite_i,
    input  logic [1:0]        ahbls_htrans_i,
    input  logic [2:0]        ahbls_hsize_i,
    input  logic [2:0]        ahbls_hburst_i,
    input  logic [3:0]        ahbls_hprot_i,
    input  logic              ahbls_hmastlock_i,
    input  logic [W_DATA-1:0] ahbls_hwdata_i,
    output logic [W_DATA-1:0] ahbls_hrdata_o,
    input  logic              ahbls_hexcl_i,
    input  logic [7:0]        ahbls_hmaster_i,
    output logic              ahbls_hexokay_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = W_DATA / 8;
    localparam logic [W_ADDR-1:0] ADDR_LIMIT = W_ADDR'(DEPTH * 4);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    // Control state
    state_t               state_q;
    logic                 hready_resp_q;
    logic                 hresp_q;
    logic                 hexokay_q, hexokay_d;
    logic [W_DATA-1:0]    hrdata_q, hrdata_d;
    logic                 dp_commit_q;           // data-phase write that will be committed
    logic [N_MASTERS-1:0] resv_vld_q, resv_vld_d;

    // Data-phase payload (no reset needed; qualified by dp_commit_q)
    logic [AW-1:0]        dp_word_q;
    logic [NB-1:0]        dp_strb_q;
    logic [AW-1:0]        resv_addr_q [N_MASTERS];
    logic [AW-1:0]        resv_addr_d [N_MASTERS];

    logic [W_DATA-1:0]    mem_q [DEPTH];

    logic                 acc;
    logic                 is_err;
    logic                 misalign;
    logic [AW-1:0]        a_word;
    logic [NB-1:0]        a_strb;
    logic                 commit;
    logic [N_MASTERS-1:0] m_sel;
    logic                 m_valid;
    logic                 excl_wr_ok;
    logic                 wr_go;
    logic [W_DATA-1:0]    rd_word;
    logic                 unused_inputs;

    assign unused_inputs = ^{ahbls_hburst_i, ahbls_hprot_i, ahbls_hmastlock_i};

    // No accept in ERR1: the bus is held by our own wait state.
    assign acc      = ahbls_hready_i && ahbls_htrans_i[1] && (state_q != ST_ERR1);
    assign misalign = ((ahbls_hsize_i == 3'd1) && ahbls_haddr_i[0]) ||
                      ((ahbls_hsize_i == 3'd2) && (ahbls_haddr_i[1:0] != 2'b00));
    assign is_err   = (ahbls_haddr_i >= ADDR_LIMIT) || (ahbls_hsize_i > 3'd2) || misalign;
    assign a_word   = ahbls_haddr_i[AW+1:2];
    assign commit   = (state_q == ST_DATA) && dp_commit_q;

    always_comb begin
        case (ahbls_hsize_i)
            3'd0:    a_strb = 4'b0001 << ahbls_haddr_i[1:0];
            3'd1:    a_strb = ahbls_haddr_i[1] ? 4'b1100 : 4'b0011;
            default: a_strb = 4'b1111;
        endcase
    end

    // Reservation entry selected by hmaster; IDs beyond the table select nothing.
    always_comb begin
        m_sel = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_sel[i] = (8'(i) == ahbls_hmaster_i);
        end
        m_valid = |m_sel;
    end

    // An SC also loses if the write completing on this same edge hits its word:
    // that write precedes it in bus order.
    always_comb begin
        excl_wr_ok = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (m_sel[i] && resv_vld_q[i] && (resv_addr_q[i] == a_word)) begin
                excl_wr_ok = 1'b1;
            end
        end
        if (commit && (dp_word_q == a_word)) begin
            excl_wr_ok = 1'b0;
        end
    end

    assign wr_go = acc && !is_err && ahbls_hwrite_i && (!ahbls_hexcl_i || excl_wr_ok);

    // Read path with forwarding of the lanes being written this edge.
    always_comb begin
        rd_word = mem_q[a_word];
        for (int b = 0; b < NB; b++) begin
            if (commit && (dp_word_q == a_word) && dp_strb_q[b]) begin
                rd_word[8*b +: 8] = ahbls_hwdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        hexokay_d = hexokay_q;
        hrdata_d  = hrdata_q;
        if (acc) begin
            if (is_err || !ahbls_hexcl_i) begin
                hexokay_d = 1'b0;
            end else if (ahbls_hwrite_i) begin
                hexokay_d = excl_wr_ok;
            end else begin
                hexokay_d = m_valid;
            end
            if (!is_err && !ahbls_hwrite_i) begin
                hrdata_d = rd_word;
            end
        end
    end

    // Kills from the completing write first, then the address-phase update,
    // so an LR set on the same edge overrides a kill.
    always_comb begin
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        if (commit) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (resv_addr_q[i] == dp_word_q) begin
                    resv_vld_d[i] = 1'b0;
                end
            end
        end
        if (acc && !is_err && ahbls_hexcl_i) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (m_sel[i]) begin
                    if (ahbls_hwrite_i) begin
                        resv_vld_d[i] = 1'b0;
                    end else begin
                        resv_vld_d[i]  = 1'b1;
                        resv_addr_d[i] = a_word;
                    end
                end
            end
        end
    end

    // Address phase -> data phase boundary: control FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
            hexokay_q     <= 1'b0;
            hrdata_q      <= '0;
            dp_commit_q   <= 1'b0;
            resv_vld_q    <= '0;
        end else begin
            hexokay_q   <= hexokay_d;
            hrdata_q    <= hrdata_d;
            dp_commit_q <= wr_go;
            resv_vld_q  <= resv_vld_d;
            if (state_q == ST_ERR1) begin
                state_q       <= ST_ERR2;
                hready_resp_q <= 1'b1;
                hresp_q       <= 1'b1;
            end else if (acc && is_err) begin
                state_q       <= ST_ERR1;
                hready_resp_q <= 1'b0;
                hresp_q       <= 1'b1;
            end else if (acc) begin
                state_q       <= ST_DATA;
                hready_resp_q <= 1'b1;
                hresp_q       <= 1'b0;
            end else begin
                state_q       <= ST_IDLE;
                hready_resp_q <= 1'b1;
                hresp_q       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        resv_addr_q <= resv_addr_d;
        if (acc) begin
            dp_word_q <= a_word;
            dp_strb_q <= a_strb;
        end
    end

    // Data phase end: commit strobed lanes; reset drops an in-flight write.
    always_ff @(posedge clk_i) begin
        if (commit && !rst_i) begin
            for (int b = 0; b < NB; b++) begin
                if (dp_strb_q[b]) begin
                    mem_q[dp_word_q][8*b +: 8] <= ahbls_hwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign ahbls_hready_resp_o = hready_resp_q;
    assign ahbls_hresp_o       = hresp_q;
    assign ahbls_hexokay_o     = hexokay_q;
    assign ahbls_hrdata_o      = hrdata_q;

endmodule

// File: tb/tb_ahbl_excl_sram.sv
// Directed testbench for ahbl_excl_sram: bypass, byte lanes, LR/SC,
// reservation kills, error responses, stalls and reset behaviour.
module tb_ahbl_excl_sram;

    localparam int W_ADDR    = 32;
    localparam int W_DATA    = 32;
    localparam int DEPTH     = 1024;
    localparam int N_MASTERS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_n = 1'b1;
    logic        hready, hready_resp, hresp, hwrite, hexcl, hexokay;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [7:0]  hmaster;
    int          n_run = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign hready = hready_resp & stall_n;

    ahbl_excl_sram #(
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .DEPTH(DEPTH), .N_MASTERS(N_MASTERS)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ahbls_hready_i     (hready),
        .ahbls_hready_resp_o(hready_resp),
        .ahbls_hresp_o      (hresp),
        .ahbls_haddr_i      (haddr),
        .ahbls_hwrite_i     (hwrite),
        .ahbls_htrans_i     (htrans),
        .ahbls_hsize_i      (hsize),
        .ahbls_hburst_i     (3'b000),
        .ahbls_hprot_i      (4'b0011),
        .ahbls_hmastlock_i  (1'b0),
        .ahbls_hwdata_i     (hwdata),
        .ahbls_hrdata_o     (hrdata),
        .ahbls_hexcl_i      (hexcl),
        .ahbls_hmaster_i    (hmaster),
        .ahbls_hexokay_o    (hexokay)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic x, input logic [7:0] m);
        htrans = 2'b10; hwrite = w; haddr = a; hsize = sz; hexcl = x; hmaster = m;
    endtask

    task automatic idle();
        htrans = 2'b00; hwrite = 1'b0; hexcl = 1'b0;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                         input logic x, input logic [7:0] m);
        addr_ph(1'b1, a, sz, x, m);
        tick();
        hwdata = d;
        idle();
        tick();
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [2:0] sz, input logic x,
                         input logic [7:0] m);
        addr_ph(1'b0, a, sz, x, m);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); haddr = '0; hsize = 3'd2; hmaster = '0; hwdata = '0;
        rst = 1'b1;
        tick(); tick();
        n_run++; if (hready_resp !== 1'b1) begin n_fail++; $display("FAIL reset_hready_resp: got %b want 1", hready_resp); end
        n_run++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b want 0", hresp); end
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL reset_hexokay: got %b want 0", hexokay); end
        n_run++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        addr_ph(1'b1, 32'h100, 3'd2, 1'b0, 8'd0);
        tick();
        hwdata = 32'hDEADBEEF;
        addr_ph(1'b0, 32'h100, 3'd2, 1'b0, 8'd0);
        tick();
        idle();
        n_run++; if (hrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_rdata: got %h want deadbeef", hrdata); end
        n_run++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL bypass_hresp: got %b want 0", hresp); end
        n_run++; if (hready_resp !== 1'b1) begin n_fail++; $display("FAIL bypass_hready_resp: got %b want 1", hready_resp); end
        tick();
    endtask

    task automatic test_byte_lanes();
        do_wr(32'h100, 3'd2, 32'h11223344, 1'b0, 8'd0);
        do_wr(32'h103, 3'd0, 32'h5A000000, 1'b0, 8'd0);
        do_rd(32'h100, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'h5A223344) begin n_fail++; $display("FAIL byte_write: got %h want 5a223344", hrdata); end
        do_wr(32'h108, 3'd2, 32'h11223344, 1'b0, 8'd0);
        do_wr(32'h10A, 3'd1, 32'hBEEF0000, 1'b0, 8'd0);
        do_rd(32'h108, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL half_write: got %h want beef3344", hrdata); end
        tick();
    endtask

    task automatic test_lr_sc();
        do_rd(32'h200, 3'd2, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b1) begin n_fail++; $display("FAIL lr_hexokay: got %b want 1", hexokay); end
        do_wr(32'h200, 3'd2, 32'd7, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b1) begin n_fail++; $display("FAIL sc_ok_hexokay: got %b want 1", hexokay); end
        do_rd(32'h200, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'd7) begin n_fail++; $display("FAIL sc_ok_mem: got %h want 7", hrdata); end
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL plain_rd_hexokay: got %b want 0", hexokay); end
        do_wr(32'h200, 3'd2, 32'd8, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL sc2_hexokay: got %b want 0", hexokay); end
        do_rd(32'h200, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'd7) begin n_fail++; $display("FAIL sc2_mem: got %h want 7", hrdata); end
        tick();
    endtask

    task automatic test_kill();
        do_rd(32'h200, 3'd2, 1'b1, 8'd0);
        do_wr(32'h200, 3'd2, 32'd9, 1'b0, 8'd1);
        do_wr(32'h200, 3'd2, 32'd7, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL kill_sc_hexokay: got %b want 0", hexokay); end
        do_rd(32'h200, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'd9) begin n_fail++; $display("FAIL kill_mem: got %h want 9", hrdata); end
        do_rd(32'h200, 3'd2, 1'b1, 8'd0);
        do_wr(32'h204, 3'd2, 32'd1, 1'b0, 8'd1);
        do_wr(32'h200, 3'd2, 32'd7, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b1) begin n_fail++; $display("FAIL nokill_sc_hexokay: got %b want 1", hexokay); end
        do_rd(32'h200, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'd7) begin n_fail++; $display("FAIL nokill_mem: got %h want 7", hrdata); end
        tick();
    endtask

    task automatic test_same_edge();
        addr_ph(1'b1, 32'h200, 3'd2, 1'b0, 8'd1);
        tick();
        hwdata = 32'h55;
        addr_ph(1'b0, 32'h200, 3'd2, 1'b1, 8'd0);
        tick();
        idle();
        n_run++; if (hrdata !== 32'h55) begin n_fail++; $display("FAIL same_edge_lr_data: got %h want 55", hrdata); end
        n_run++; if (hexokay !== 1'b1) begin n_fail++; $display("FAIL same_edge_lr_hexokay: got %b want 1", hexokay); end
        do_wr(32'h200, 3'd2, 32'h66, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b1) begin n_fail++; $display("FAIL same_edge_sc: got %b want 1", hexokay); end
        do_rd(32'h200, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'h66) begin n_fail++; $display("FAIL same_edge_mem: got %h want 66", hrdata); end
        tick();
    endtask

    task automatic test_err();
        addr_ph(1'b0, 32'h1000, 3'd2, 1'b0, 8'd0);
        tick();
        idle();
        n_run++; if (hready_resp !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL oor_err1: got ready=%b resp=%b want 0/1", hready_resp, hresp); end
        tick();
        n_run++; if (hready_resp !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL oor_err2: got ready=%b resp=%b want 1/1", hready_resp, hresp); end
        tick();
        n_run++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL oor_done: got resp=%b want 0", hresp); end
        addr_ph(1'b0, 32'h100, 3'd3, 1'b0, 8'd0);
        tick();
        idle();
        n_run++; if (hresp !== 1'b1 || hready_resp !== 1'b0) begin n_fail++; $display("FAIL size_err1: got ready=%b resp=%b want 0/1", hready_resp, hresp); end
        tick(); tick();
        addr_ph(1'b1, 32'h102, 3'd2, 1'b0, 8'd0);
        tick();
        hwdata = 32'hFFFFFFFF;
        idle();
        n_run++; if (hready_resp !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL misalign_err1: got ready=%b resp=%b want 0/1", hready_resp, hresp); end
        tick();
        n_run++; if (hready_resp !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL misalign_err2: got ready=%b resp=%b want 1/1", hready_resp, hresp); end
        addr_ph(1'b1, 32'h104, 3'd2, 1'b0, 8'd0);
        tick();
        n_run++; if (hready_resp !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL err2_accept: got ready=%b resp=%b want 1/0", hready_resp, hresp); end
        hwdata = 32'hCAFEF00D;
        idle();
        tick();
        do_rd(32'h100, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'h5A223344) begin n_fail++; $display("FAIL err_no_write: got %h want 5a223344", hrdata); end
        do_rd(32'h104, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err2_write: got %h want cafef00d", hrdata); end
        tick();
    endtask

    task automatic test_no_entry();
        do_wr(32'h300, 3'd2, 32'h12345678, 1'b0, 8'd0);
        do_rd(32'h300, 3'd2, 1'b1, 8'd2);
        n_run++; if (hrdata !== 32'h12345678) begin n_fail++; $display("FAIL noentry_lr_data: got %h want 12345678", hrdata); end
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL noentry_lr_hexokay: got %b want 0", hexokay); end
        do_wr(32'h300, 3'd2, 32'h0, 1'b1, 8'd2);
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL noentry_sc_hexokay: got %b want 0", hexokay); end
        do_rd(32'h300, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'h12345678) begin n_fail++; $display("FAIL noentry_sc_mem: got %h want 12345678", hrdata); end
        tick();
    endtask

    task automatic test_stall();
        addr_ph(1'b1, 32'h400, 3'd2, 1'b0, 8'd0);
        tick();
        hwdata = 32'hA5A5A5A5;
        stall_n = 1'b0;
        addr_ph(1'b0, 32'h400, 3'd2, 1'b0, 8'd0);
        tick();
        n_run++; if (hrdata !== 32'h12345678) begin n_fail++; $display("FAIL stall_hold: got %h want 12345678", hrdata); end
        stall_n = 1'b1;
        tick();
        idle();
        n_run++; if (hrdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL stall_read: got %h want a5a5a5a5", hrdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_rd(32'h300, 3'd2, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b1 || hrdata !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_lr: got ok=%b data=%h want 1/12345678", hexokay, hrdata); end
        addr_ph(1'b1, 32'h300, 3'd2, 1'b0, 8'd0);
        tick();
        hwdata = 32'hFFFFFFFF;
        idle();
        rst = 1'b1;
        tick();
        n_run++; if (hready_resp !== 1'b1 || hresp !== 1'b0 || hexokay !== 1'b0 || hrdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got ready=%b resp=%b ok=%b data=%h want 1/0/0/0", hready_resp, hresp, hexokay, hrdata);
        end
        rst = 1'b0;
        tick();
        do_wr(32'h300, 3'd2, 32'hBAD, 1'b1, 8'd0);
        n_run++; if (hexokay !== 1'b0) begin n_fail++; $display("FAIL rstmid_resv_cleared: got %b want 0", hexokay); end
        do_rd(32'h300, 3'd2, 1'b0, 8'd0);
        n_run++; if (hrdata !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_dropped: got %h want 12345678", hrdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_byte_lanes();
        test_lr_sc();
        test_kill();
        test_same_edge();
        test_err();
        test_no_entry();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahbl_excl_sram.md
# ahbl_excl_sram

AHB-Lite slave with a single-ported word-organised SRAM and an exclusive-access monitor, sitting downstream of the strict-priority N:1 arbiter on the shared memory bus. It consumes the arbiter's forwarded `hexcl`/`hmaster` sideband and returns `hexokay`, giving harts LR/SC semantics on shared memory. Zero-wait-state reads and writes, with a two-cycle ERROR response for illegal accesses.

## Interface
- `W_ADDR`, 32, address width.
- `W_DATA`, 32, data width. Fixed at 32; byte lanes = 4.
- `DEPTH`, 1024, memory depth in words. Valid byte addresses are `0 .. DEPTH*4-1`, and upper address bits must be zero.
- `N_MASTERS`, 2, number of reservation entries, indexed by `hmaster`.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ahbls_hready` in 1: bus-wide ready. An address phase is accepted when `hready && htrans[1]`.
- `ahbls_hready_resp` out 1: slave ready.
- `ahbls_hresp` out 1: 1 = ERROR.
- `ahbls_haddr` in `W_ADDR`: transfer address.
- `ahbls_hwrite` in 1: 1 = write.
- `ahbls_htrans` in 2: transfer type.
- `ahbls_hsize` in 3: transfer size.
- `ahbls_hburst` in 3: burst type, ignored.
- `ahbls_hprot` in 4: protection, ignored.
- `ahbls_hmastlock` in 1: locked transfer, ignored.
- `ahbls_hwdata` in `W_DATA`: write data.
- `ahbls_hrdata` out `W_DATA`: read data.
- `ahbls_hexcl` in 1: exclusive transfer.
- `ahbls_hmaster` in 8: master ID.
- `ahbls_hexokay` out 1: exclusive success, valid in the data phase.

## Operation
- **Address phase accept.** Capture `haddr`, `hwrite`, `hsize`, `hexcl` and `hmaster` into data-phase registers. Then classify the transfer:
  - ERR: address out of range, `hsize > 2`, or a misaligned address for the given size.
  - RD: a legal read.
  - WR: a legal write.
- **Byte strobes.** Derived from `hsize` and `haddr[1:0]`, little-endian:
  - byte: lane `haddr[1:0]`.
  - halfword: lanes `{haddr[1],0}` and `+1`.
  - word: all four lanes.
- **RD.** The array is read at the address-phase edge, and `hrdata` is valid in the data phase.
- **RD bypass.** If the immediately preceding transfer was a WR to the same word still in its data phase, the lanes it writes are forwarded from `hwdata`. Read-after-write therefore returns the new data with zero wait.
- **WR.** The strobed lanes of `hwdata` are committed to the array at the end of the data phase.
- **ERR.** No array access and no reservation change.
- **Reservations.** There are `N_MASTERS` entries of {valid, word address}. Entry index = `hmaster`. If `hmaster >= N_MASTERS`, no entry applies and exclusives always fail.
- **Exclusive RD:**
  - set entry[m] to {1, word}.
  - `hexokay` = 1 if the entry exists, else 0.
  - data is returned normally.
- **Exclusive WR:**
  - Success iff entry[m] is valid and its address equals the word. On success, commit the write and assert `hexokay` = 1.
  - On failure, suppress the write, assert `hexokay` = 0, and give an OKAY response.
  - In both cases entry[m] is cleared.
- **Reservation kill.** Any committed write, exclusive or normal, from any master clears every entry whose address equals the written word.
- **Non-exclusive transfers.** `hexokay` = 0.
- **Bus ordering (same edge).** When a data-phase write kill and an address-phase exclusive-read set hit the same entry on the same edge, the set wins: the read is later in bus order.
- **Multiple kills.** Multiple entries may be killed in one cycle.

## Timing
- **Reset values.** `hready_resp` = 1, `hresp` = 0, `hexokay` = 0, `hrdata` = 0. All reservations are invalid and the data-phase registers are idle. Memory contents are not reset.
- **Reset mid-transfer.** An in-flight write is dropped (not committed). Reset takes priority over every other update.
- **OKAY transfers.** Zero wait: `hready_resp` = 1 throughout the data phase. The data phase lasts exactly one cycle unless the bus stalls.
- **Bus stall.** `ahbls_hready` may be held low by another slave's data phase. No address phase is accepted while it is low. A pending data-phase commit happens exactly once, on the cycle this slave's `hready_resp` completes it.
- **ERR state machine:**
  - IDLE → ERR1 on accepting an ERR transfer.
  - ERR1: `hready_resp` = 0, `hresp` = 1.
  - ERR1 → ERR2 unconditionally. ERR2: `hready_resp` = 1, `hresp` = 1.
  - ERR2 → IDLE, or → DATA if a new transfer is accepted in ERR2.
- **After an ERR.** The master may issue IDLE in ERR2. A transfer accepted in ERR2 is processed normally.
- **Output timing.** `hexokay` and `hrdata` are registered: valid the cycle after address-phase accept and held until the next accept.

## Test plan
- Reset, then word write `0x100` = `0xDEADBEEF`, then read `0x100` back-to-back → `0xDEADBEEF` via bypass, `hresp` = 0, no wait states.
- Byte write `0x103` = `0x5A` over `0x11223344`, then word read → `0x5A223344`.
- Master 0 LR `0x200`, master 0 SC `0x200` = 7 → `hexokay` = 1 and memory = 7. A second SC to `0x200` → `hexokay` = 0 and memory unchanged.
- Master 0 LR `0x200`, master 1 plain write `0x200` = 9, master 0 SC `0x200` = 7 → `hexokay` = 0, memory = 9. A master 1 write to `0x204` instead does not kill, so the SC succeeds.
- Read at `DEPTH*4`, and word access at `0x102` → ERR1 then ERR2, `hresp` = 1 for 2 cycles with `hready_resp` 0 then 1, no memory change. A write issued in ERR2 commits normally.
- Exclusive read with `hmaster` = `N_MASTERS` → data returned, `hexokay` = 0. Reset asserted during a write data phase → write not committed, all outputs at reset values.
